// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions: main-control opcodes plus the memory-access
// unit's FSM state and request-type encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mau_state_t;

    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_LOAD    = 2'd1,
        REQ_STORE   = 2'd2,
        REQ_ILLEGAL = 2'd3
    } req_type_t;

    function automatic req_type_t decode_req(input logic mem_read, input logic mem_write);
        req_type_t t;
        case ({mem_read, mem_write})
            2'b10:   t = REQ_LOAD;
            2'b01:   t = REQ_STORE;
            2'b11:   t = REQ_ILLEGAL;
            default: t = REQ_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, registered read.
// Contents are intentionally not reset.
module data_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: IDLE/ACCESS/DONE FSM with a LATENCY-cycle
// access window, stalling upstream and producing the register writeback.
module mem_access_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [31:0] alu_result,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LATENCY);

    mau_state_t    r_state;
    logic [3:0]    r_cnt;
    req_type_t     r_type;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_alu;
    logic          r_regwrite;
    logic          r_memtoreg;
    logic          r_wb_valid;
    logic [31:0]   r_wb_data;
    logic          r_wb_mem;
    logic          r_err;

    req_type_t     w_req;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_last;
    logic          w_mem_we;
    logic          w_mem_re;
    logic [31:0]   w_rdata;

    assign w_req        = decode_req(MemRead, MemWrite);
    assign w_misaligned = |alu_result[1:0];
    assign w_accept     = (r_state == ST_IDLE) && !w_misaligned &&
                          ((w_req == REQ_LOAD) || (w_req == REQ_STORE));
    assign w_last       = (r_state == ST_ACCESS) && (r_cnt == 4'd1);
    assign w_mem_we     = w_last && (r_type == REQ_STORE) && !rst;
    assign w_mem_re     = w_last && (r_type == REQ_LOAD) && !rst;

    assign stall = !rst && (w_accept || (r_state == ST_ACCESS));

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_mem   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_ACCESS;
                        r_cnt      <= LAT4;
                        r_idx      <= alu_result[AW+1:2];
                        r_wdata    <= wdata;
                        r_type     <= w_req;
                        r_regwrite <= RegWrite;
                        r_memtoreg <= MemToReg;
                        r_alu      <= alu_result;
                    end else if (w_req == REQ_NONE) begin
                        r_wb_valid <= RegWrite;
                        if (RegWrite) begin
                            r_wb_data <= alu_result;
                        end
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                        if ((r_type == REQ_LOAD) && r_regwrite) begin
                            r_wb_valid <= 1'b1;
                            if (r_memtoreg) begin
                                r_wb_mem <= 1'b1;
                            end else begin
                                r_wb_data <= r_alu;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // rdata_q is only valid from DONE on, so wb_data shows it
                    // directly for that cycle and keeps a copy for the hold.
                    r_state <= ST_IDLE;
                    if (r_wb_mem) begin
                        r_wb_data <= w_rdata;
                        r_wb_mem  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_data  = r_wb_mem ? w_rdata : r_wb_data;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// instruction stream against an instruction-level timing/memory model.
module tb_mem_access_unit;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, MemToReg, RegWrite;
    logic [31:0] alu_result, wdata;
    logic        stall, wb_valid, err;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .alu_result (alu_result),
        .wdata      (wdata),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .err        (err)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_wb     = 0;
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] hold;
    logic        pend_valid, pend_err;
    logic [31:0] pend_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Checks one cycle at the falling edge, then advances to just after the next rising edge.
    task automatic check_cycle(input logic exp_stall, input logic exp_valid, input logic exp_err);
        @(negedge clk);
        if (wb_valid === 1'b1) n_wb++;
        chk("stall",    32'(stall),    32'(exp_stall));
        chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
        chk("err",      32'(err),      32'(exp_err));
        chk("wb_data",  wb_data,       hold);
        @(posedge clk);
        #1;
    endtask

    task automatic take_pending(output logic v, output logic e);
        v = pend_valid;
        e = pend_err;
        if (pend_valid) hold = pend_data;
        pend_valid = 1'b0;
        pend_err   = 1'b0;
    endtask

    // Presents one instruction, held for as long as the model says it occupies the unit.
    task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] addr, input logic [31:0] data);
        logic mem_op, bad, pv, pe, exp_v;
        int   idx;
        MemRead = rd; MemWrite = wr; MemToReg = m2r; RegWrite = rw;
        alu_result = addr; wdata = data;
        mem_op = (rd ^ wr) && (addr % 4 == 0);
        bad    = (rd && wr) || ((rd ^ wr) && (addr % 4 != 0));
        idx    = int'((addr / 4) % DEPTH);
        if (mem_op) begin
            take_pending(pv, pe);
            check_cycle(1'b1, pv, pe);
            for (int k = 1; k <= LAT; k++) check_cycle(1'b1, 1'b0, 1'b0);
            exp_v = rd && rw;
            if (exp_v) hold = m2r ? mdl_mem[idx] : addr;
            if (wr) mdl_mem[idx] = data;
            check_cycle(1'b0, exp_v, 1'b0);
        end else begin
            take_pending(pv, pe);
            check_cycle(1'b0, pv, pe);
            pend_valid = !rd && !wr && rw;
            pend_data  = addr;
            pend_err   = bad;
        end
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0;
        alu_result = '0; wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        pend_valid = 1'b0; pend_err = 1'b0; hold = '0;
        check_cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic        pv, pe;
        int          n0, kind;
        logic [31:0] a;

        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0;
        alu_result = '0; wdata = '0;
        pend_valid = 1'b0; pend_err = 1'b0; pend_data = '0; hold = '0;
        do_reset();

        for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), $urandom);

        // Store then load
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
        chk("load_deadbeef", hold, 32'hDEAD_BEEF);

        // R-type writeback
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0);
        idle();
        chk("rtype_1234", hold, 32'h1234);

        // Misaligned store and illegal request leave memory untouched
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0BAD_0020);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h13, 32'h0000_0BAD);
        issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0000_0BAD);
        idle();
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
        chk("illegal_nochange", hold, 32'h0BAD_0020);

        // Address wrap-around
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h55);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        chk("wrap_0x55", hold, 32'h55);

        // Reset during the second ACCESS cycle aborts the store
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h1111_2222);
        MemRead = 1'b0; MemWrite = 1'b1; MemToReg = 1'b0; RegWrite = 1'b0;
        alu_result = 32'h8; wdata = 32'h0000_AAAA;
        take_pending(pv, pe);
        check_cycle(1'b1, pv, pe);
        check_cycle(1'b1, 1'b0, 1'b0);
        rst = 1'b1; MemWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        pend_valid = 1'b0; pend_err = 1'b0; hold = '0;
        check_cycle(1'b0, 1'b0, 1'b0);
        check_cycle(1'b0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0);
        chk("abort_old_value", hold, 32'h1111_2222);

        // Back-to-back load, load, R-type
        n0 = n_wb;
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
        issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h777, 32'h0);
        idle();
        chk("b2b_wb_count", 32'(n_wb - n0), 32'd3);

        // Random instruction stream
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 5));
            a    = $urandom & ~32'h3;
            case (kind)
                0: issue(1'b0, 1'b1, 1'($urandom), 1'($urandom), a, $urandom);
                1: issue(1'b1, 1'b0, 1'($urandom), 1'($urandom), a, $urandom);
                2: issue(1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
                3: issue(1'b1, 1'b1, 1'($urandom), 1'($urandom), $urandom, $urandom);
                4: issue(1'($urandom), 1'b0, 1'b1, 1'b1, a | 32'($urandom_range(1, 3)), $urandom);
                default: issue(1'b1, 1'b0, 1'b1, 1'b1, a, $urandom);
            endcase
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
